// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//
// Serial configuration loader for the CLB. Hunts a PRE_W-bit preamble in the
// serial stream, shifts in one CFG_W-bit frame LSB first, checks even parity
// over data plus parity bit, and on success commits the frame to CFG. On a
// parity failure CFG keeps the last good word and ERR is raised.
//
// Optional feature macro: CLB_CFG_READBACK_EN
//   defined   : RB_REQ snapshots CFG and streams it out on RB_DOUT, LSB first,
//               qualified by RB_VALID for CFG_W cycles.
//   undefined : RB_REQ ignored, RB_DOUT = RB_VALID = 0.
//
// Ports:
//   K          clock, rising edge
//   RSTN       asynchronous active-low reset
//   DIN        serial data, sampled only when DVALID = 1
//   DVALID     data qualifier; 0 stalls the loader completely
//   ABORT      synchronous frame abort (wins over DVALID, bit discarded)
//   CFG        last committed configuration word
//   CFG_VALID  one-cycle pulse on each commit
//   BUSY       high while a frame is being received (LOAD/PAR)
//   DONE       sticky: at least one good frame since reset
//   ERR        last completed frame failed parity
//   RB_REQ     readback request
//   RB_DOUT    readback serial data
//   RB_VALID   readback data qualifier
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int               CFG_W    = 37,
    parameter int               PRE_W    = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b0010,
    parameter logic [CFG_W-1:0] CFG_RST  = 37'h3802A0116
) (
    input  logic             K,
    input  logic             RSTN,
    input  logic             DIN,
    input  logic             DVALID,
    input  logic             ABORT,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    input  logic             RB_REQ,
    output logic             RB_DOUT,
    output logic             RB_VALID
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PAR} state_t;

    state_t           state_reg, state_next;
    // Only the newest PRE_W-1 bits are stored: the oldest bit of the window
    // would be shifted out before it could ever be compared again.
    logic [PRE_W-2:0] hist_reg, hist_next;
    logic [PRE_W-1:0] win_shift;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CFG_W-1:0] sr_reg, sr_next;
    logic [CFG_W-1:0] cfg_reg, cfg_next;
    logic             cfg_valid_reg, cfg_valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    always_ff @(posedge K or negedge RSTN) begin
        if (!RSTN) begin
            state_reg     <= IDLE;
            hist_reg      <= '0;
            cnt_reg       <= '0;
            sr_reg        <= '0;
            cfg_reg       <= CFG_RST;
            cfg_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            cnt_reg       <= cnt_next;
            sr_reg        <= sr_next;
            cfg_reg       <= cfg_next;
            cfg_valid_reg <= cfg_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        cnt_next       = cnt_reg;
        sr_next        = sr_reg;
        cfg_next       = cfg_reg;
        cfg_valid_next = 1'b0;
        done_next      = done_reg;
        err_next       = err_reg;
        win_shift      = {hist_reg, DIN};

        if (ABORT) begin
            state_next = IDLE;
            hist_next  = '0;
            cnt_next   = '0;
        end else if (DVALID) begin
            case (state_reg)
                IDLE: begin
                    if (win_shift == PREAMBLE) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                        hist_next  = '0;
                    end else begin
                        hist_next  = win_shift[PRE_W-2:0];
                    end
                end
                LOAD: begin
                    sr_next[cnt_reg] = DIN;
                    if (cnt_reg == LAST_BIT) begin
                        state_next = PAR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                    end
                end
                PAR: begin
                    // Even parity: data bits and parity bit XOR to zero.
                    if (^{sr_reg, DIN} == 1'b0) begin
                        cfg_next       = sr_reg;
                        cfg_valid_next = 1'b1;
                        done_next      = 1'b1;
                        err_next       = 1'b0;
                    end else begin
                        err_next       = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    hist_next  = '0;
                    cnt_next   = '0;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    assign CFG       = cfg_reg;
    assign CFG_VALID = cfg_valid_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

`ifdef CLB_CFG_READBACK_EN
    logic [CFG_W-1:0] rb_snap_reg;
    logic [CNT_W-1:0] rb_idx_reg;
    logic             rb_dout_reg;
    logic             rb_valid_reg;

    // The request edge already presents bit 0 (taken straight from CFG), so
    // rb_idx_reg points at the next bit to present from the snapshot.
    always_ff @(posedge K or negedge RSTN) begin
        if (!RSTN) begin
            rb_snap_reg  <= '0;
            rb_idx_reg   <= '0;
            rb_dout_reg  <= 1'b0;
            rb_valid_reg <= 1'b0;
        end else if (!rb_valid_reg) begin
            if (RB_REQ) begin
                rb_snap_reg  <= cfg_reg;
                rb_dout_reg  <= cfg_reg[0];
                rb_valid_reg <= 1'b1;
                rb_idx_reg   <= CNT_W'(1);
            end
        end else if (rb_idx_reg == CNT_W'(CFG_W)) begin
            rb_valid_reg <= 1'b0;
            rb_dout_reg  <= 1'b0;
            rb_idx_reg   <= '0;
        end else begin
            rb_dout_reg <= rb_snap_reg[rb_idx_reg];
            rb_idx_reg  <= rb_idx_reg + 1'b1;
        end
    end

    assign RB_DOUT  = rb_dout_reg;
    assign RB_VALID = rb_valid_reg;
`else
    logic rb_req_unused;
    assign rb_req_unused = RB_REQ;
    assign RB_DOUT       = 1'b0;
    assign RB_VALID      = 1'b0;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

    localparam logic [36:0] CFG_RST = 37'h3802A0116;

    logic        K;
    logic        RSTN;
    logic        DIN;
    logic        DVALID;
    logic        ABORT;
    logic [36:0] CFG;
    logic        CFG_VALID;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        RB_REQ;
    logic        RB_DOUT;
    logic        RB_VALID;

    int n_cmp = 0;
    int n_err = 0;

    clb_cfg_loader dut (
        .K        (K),
        .RSTN     (RSTN),
        .DIN      (DIN),
        .DVALID   (DVALID),
        .ABORT    (ABORT),
        .CFG      (CFG),
        .CFG_VALID(CFG_VALID),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .RB_REQ   (RB_REQ),
        .RB_DOUT  (RB_DOUT),
        .RB_VALID (RB_VALID)
    );

    initial K = 1'b0;
    always #5 K = ~K;

    // One accepted bit; optional stall cycle (DVALID low, junk DIN) first.
    task automatic send_bit(input logic b, input bit stall);
        if (stall) begin
            @(negedge K);
            DVALID = 1'b0;
            DIN    = ~b;
            @(posedge K);
            #1;
        end
        @(negedge K);
        DIN    = b;
        DVALID = 1'b1;
        @(posedge K);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge K);
        DVALID = 1'b0;
        ABORT  = 1'b0;
        RB_REQ = 1'b0;
        @(posedge K);
        #1;
    endtask

    task automatic send_preamble(input bit stall);
        logic [3:0] pre;
        pre = 4'b0010;
        for (int i = 3; i >= 0; i--) send_bit(pre[i], stall);
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_preamble: got %b want 1", BUSY);
        end
    endtask

    // Preamble, 37 data bits LSB first, parity; returns right after parity edge.
    task automatic send_frame(input logic [36:0] data, input logic par, input bit stall);
        send_preamble(stall);
        for (int i = 0; i < 37; i++) send_bit(data[i], stall);
        n_cmp++;
        if (BUSY !== 1'b1 || CFG_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL before_parity: got busy=%b valid=%b want busy=1 valid=0", BUSY, CFG_VALID);
        end
        send_bit(par, stall);
        $display("frame data=%h par=%b stall=%0d -> cfg=%h valid=%b err=%b", data, par, stall, CFG, CFG_VALID, ERR);
    endtask

    task automatic check_commit(input logic [36:0] exp, input string tag);
        n_cmp++;
        if (CFG_VALID !== 1'b1 || CFG !== exp || DONE !== 1'b1 || ERR !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL %s_commit: got cfg=%h v=%b d=%b e=%b b=%b want cfg=%h v=1 d=1 e=0 b=0",
                     tag, CFG, CFG_VALID, DONE, ERR, BUSY, exp);
        end
        idle_cycle();
        n_cmp++;
        if (CFG_VALID !== 1'b0 || CFG !== exp) begin
            n_err++;
            $display("FAIL %s_pulse_drop: got cfg=%h v=%b want cfg=%h v=0", tag, CFG, CFG_VALID, exp);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; DIN = 1'b0; DVALID = 1'b0; ABORT = 1'b0; RB_REQ = 1'b0;
        repeat (3) @(posedge K);
        @(negedge K);
        RSTN = 1'b1;
        repeat (5) @(posedge K);
        #1;
        n_cmp++;
        if (CFG !== CFG_RST || DONE !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0 ||
            CFG_VALID !== 1'b0 || RB_VALID !== 1'b0 || RB_DOUT !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got cfg=%h d=%b e=%b b=%b v=%b rbv=%b want cfg=%h all flags 0",
                     CFG, DONE, ERR, BUSY, CFG_VALID, RB_VALID, CFG_RST);
        end
        $display("reset cfg=%h", CFG);
    endtask

    task automatic test_good_frame();
        send_frame(37'h0_0000_FFFF, 1'b0, 1'b0);
        check_commit(37'h0_0000_FFFF, "good");
    endtask

    task automatic test_parity_error();
        // popcount(0x123456789) = 15 -> correct parity bit is 1; send 0.
        send_frame(37'h1_2345_6789, 1'b0, 1'b0);
        n_cmp++;
        if (ERR !== 1'b1 || CFG_VALID !== 1'b0 || CFG !== 37'h0_0000_FFFF || DONE !== 1'b1) begin
            n_err++;
            $display("FAIL parity_error: got e=%b v=%b cfg=%h d=%b want e=1 v=0 cfg=00000ffff d=1",
                     ERR, CFG_VALID, CFG, DONE);
        end
        idle_cycle();
        send_frame(37'h1_2345_6789, 1'b1, 1'b0);
        check_commit(37'h1_2345_6789, "err_recover");
    endtask

    task automatic test_stall();
        // popcount(0x15555AAAA) = 17 -> parity 1.
        send_frame(37'h1_5555_AAAA, 1'b1, 1'b1);
        check_commit(37'h1_5555_AAAA, "stall");
    endtask

    task automatic test_preamble_in_data();
        // Data begins with 0,0,1,0 which must be loaded as data.
        send_frame(37'h0_0000_0004, 1'b1, 1'b0);
        check_commit(37'h0_0000_0004, "pre_in_data");
    endtask

    task automatic test_abort();
        send_preamble(1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        @(negedge K);
        ABORT = 1'b1; DVALID = 1'b1; DIN = 1'b1;
        @(posedge K);
        #1;
        n_cmp++;
        if (BUSY !== 1'b0 || CFG !== 37'h0_0000_0004 || CFG_VALID !== 1'b0 || ERR !== 1'b0 || DONE !== 1'b1) begin
            n_err++;
            $display("FAIL abort: got b=%b cfg=%h v=%b e=%b d=%b want b=0 cfg=000000004 v=0 e=0 d=1",
                     BUSY, CFG, CFG_VALID, ERR, DONE);
        end
        $display("abort busy=%b cfg=%h", BUSY, CFG);
        idle_cycle();
        send_frame(37'h0_0000_FFFF, 1'b0, 1'b0);
        check_commit(37'h0_0000_FFFF, "after_abort");
    endtask

    task automatic test_reset_midframe();
        send_preamble(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        @(negedge K);
        RSTN = 1'b0;
        #1;
        n_cmp++;
        if (CFG !== CFG_RST || DONE !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0 ||
            CFG_VALID !== 1'b0 || RB_VALID !== 1'b0 || RB_DOUT !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midframe: got cfg=%h d=%b e=%b b=%b v=%b want cfg=%h flags 0",
                     CFG, DONE, ERR, BUSY, CFG_VALID, CFG_RST);
        end
        $display("reset midframe cfg=%h busy=%b", CFG, BUSY);
        DVALID = 1'b0;
        @(negedge K);
        RSTN = 1'b1;
        send_frame(37'h1_2345_6789, 1'b1, 1'b0);
        check_commit(37'h1_2345_6789, "after_reset");
    endtask

    task automatic test_readback();
`ifdef CLB_CFG_READBACK_EN
        logic [36:0] exp;
        exp = 37'h1_2345_6789;
        @(negedge K);
        RB_REQ = 1'b1;
        @(posedge K);
        #1;
        for (int i = 0; i < 37; i++) begin
            n_cmp++;
            if (RB_VALID !== 1'b1 || RB_DOUT !== exp[i]) begin
                n_err++;
                $display("FAIL readback_bit%0d: got v=%b d=%b want v=1 d=%b", i, RB_VALID, RB_DOUT, exp[i]);
            end
            @(negedge K);
            RB_REQ = (i < 3);   // requests during readback are ignored
            @(posedge K);
            #1;
        end
        n_cmp++;
        if (RB_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL readback_end: got v=%b want 0", RB_VALID);
        end
        $display("readback of %h complete", exp);
`else
        @(negedge K);
        RB_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge K);
            #1;
            n_cmp++;
            if (RB_VALID !== 1'b0 || RB_DOUT !== 1'b0) begin
                n_err++;
                $display("FAIL readback_disabled: got v=%b d=%b want 0 0", RB_VALID, RB_DOUT);
            end
        end
        $display("readback disabled rb_valid=%b", RB_VALID);
`endif
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stall();
        test_preamble_in_data();
        test_abort();
        test_reset_midframe();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
